// File: rtl/coaster_segment_monitor_if.sv
// Bundle of ride-control inputs and monitor outputs for coaster_segment_monitor.
interface coaster_segment_monitor_if #(
    parameter int NUM_SEG  = 4,
    parameter int SPEED_W  = 9,
    parameter int WEIGHT_W = 12
);
    logic                i_start;
    logic [WEIGHT_W-1:0] i_weight;
    logic [SPEED_W-1:0]  i_speed;
    logic                i_speed_valid;
    logic [NUM_SEG-1:0]  i_ir_sensor;
    logic                i_human_control;
    logic [2:0]          o_state;
    logic [2:0]          o_segment;
    logic [1:0]          o_speed_control;
    logic                o_alarm;
    logic                o_destination;
    logic [7:0]          o_viol_cnt;

    // Ride controller / stimulus side
    modport master (
        output i_start, i_weight, i_speed, i_speed_valid, i_ir_sensor, i_human_control,
        input  o_state, o_segment, o_speed_control, o_alarm, o_destination, o_viol_cnt
    );

    // Monitor side
    modport slave (
        input  i_start, i_weight, i_speed, i_speed_valid, i_ir_sensor, i_human_control,
        output o_state, o_segment, o_speed_control, o_alarm, o_destination, o_viol_cnt
    );
endinterface

// File: rtl/coaster_segment_monitor.sv
// Roller-coaster ride monitor: load check, segment tracking, per-segment speed
// band supervision with consecutive-violation alarm, and arrival braking.
module coaster_segment_monitor #(
    parameter int NUM_SEG    = 4,
    parameter int SPEED_W    = 9,
    parameter int WEIGHT_W   = 12,
    parameter int WEIGHT_MIN = 300,
    parameter int WEIGHT_MAX = 1500,
    parameter logic [NUM_SEG*SPEED_W-1:0] MIN_V = {SPEED_W'(10), SPEED_W'(10), SPEED_W'(20), SPEED_W'(25)},
    parameter logic [NUM_SEG*SPEED_W-1:0] MAX_V = {SPEED_W'(30), SPEED_W'(20), SPEED_W'(50), SPEED_W'(30)},
    parameter int ALARM_HOLD = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    coaster_segment_monitor_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_ALARM   = 3'd2,
        S_ARRIVED = 3'd3,
        S_REJECT  = 3'd4
    } state_t;

    localparam logic [1:0]          SC_HOLD  = 2'b00;
    localparam logic [1:0]          SC_UP    = 2'b01;
    localparam logic [1:0]          SC_SLOW  = 2'b10;
    localparam logic [2:0]          LAST_SEG = 3'(NUM_SEG - 1);
    localparam logic [WEIGHT_W-1:0] W_MIN    = WEIGHT_W'(WEIGHT_MIN);
    localparam logic [WEIGHT_W-1:0] W_MAX    = WEIGHT_W'(WEIGHT_MAX);
    localparam logic [3:0]          HOLD     = 4'(ALARM_HOLD);

    state_t              state_reg, state_next;
    logic [2:0]          seg_reg, seg_next;
    logic [1:0]          speed_reg, speed_next;
    logic [7:0]          viol_reg, viol_next;
    logic [3:0]          consec_reg, consec_next;
    logic [WEIGHT_W-1:0] weight_reg, weight_next;

    // Per-segment bands and sensors widened to 8 entries so a 3-bit index is always in range
    logic [SPEED_W-1:0] min_arr [8];
    logic [SPEED_W-1:0] max_arr [8];
    logic [7:0]         sensor_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_band
            if (gi < NUM_SEG) begin : g_used
                assign min_arr[gi]    = MIN_V[gi*SPEED_W +: SPEED_W];
                assign max_arr[gi]    = MAX_V[gi*SPEED_W +: SPEED_W];
                assign sensor_ext[gi] = bus.i_ir_sensor[gi];
            end else begin : g_unused
                assign min_arr[gi]    = '0;
                assign max_arr[gi]    = '0;
                assign sensor_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // Event decode shared by the FSM and the datapath
    logic       start_idle, weight_ok, in_run, human, advance, arrive;
    logic       over, under, out_band, alarm_hit;
    logic [2:0] seg_plus1, seg_eval;
    logic [3:0] consec_base, consec_inc;

    assign start_idle  = (state_reg == S_IDLE) && bus.i_start;
    assign weight_next = start_idle ? bus.i_weight : weight_reg;
    assign weight_ok   = (weight_next > W_MIN) && (weight_next < W_MAX);
    assign in_run      = (state_reg == S_RUN);
    assign human       = bus.i_human_control;
    assign seg_plus1   = seg_reg + 3'd1;
    assign advance     = in_run && !human && (seg_reg < LAST_SEG) && sensor_ext[seg_plus1];
    assign arrive      = advance && (seg_plus1 == LAST_SEG);
    // A sample coinciding with an advance is judged against the new segment
    assign seg_eval    = advance ? seg_plus1 : seg_reg;
    assign over        = bus.i_speed > max_arr[seg_eval];
    assign under       = bus.i_speed < min_arr[seg_eval];
    assign out_band    = over || under;
    assign consec_base = advance ? 4'd0 : consec_reg;
    assign consec_inc  = (consec_base == 4'hF) ? 4'hF : consec_base + 4'd1;
    // Arrival outranks the alarm because sensor advance outranks speed evaluation
    assign alarm_hit   = in_run && !human && !arrive && bus.i_speed_valid && out_band
                         && (consec_inc >= HOLD);

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (bus.i_start) state_next = weight_ok ? S_RUN : S_REJECT;
            S_REJECT:  state_next = S_IDLE;
            S_RUN: begin
                if (human)          state_next = S_ALARM;
                else if (arrive)    state_next = S_ARRIVED;
                else if (alarm_hit) state_next = S_ALARM;
            end
            S_ALARM:   if (human) state_next = S_IDLE;
            S_ARRIVED: if (bus.i_start) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        bus.o_state         = state_reg;
        bus.o_alarm         = (state_reg == S_ALARM);
        bus.o_destination   = (state_reg == S_ARRIVED);
        bus.o_segment       = seg_reg;
        bus.o_speed_control = speed_reg;
        bus.o_viol_cnt      = viol_reg;
    end

    // Datapath next values: segment, speed command, violation counters
    always_comb begin
        seg_next    = seg_reg;
        speed_next  = speed_reg;
        viol_next   = viol_reg;
        consec_next = consec_reg;
        case (state_reg)
            S_IDLE: begin
                speed_next = SC_HOLD;
                if (start_idle && weight_ok) begin
                    seg_next    = 3'd0;
                    viol_next   = 8'd0;
                    consec_next = 4'd0;
                end
            end
            S_REJECT: speed_next = SC_HOLD;
            S_RUN: begin
                if (human) begin
                    speed_next = SC_SLOW;
                end else begin
                    if (advance) begin
                        seg_next    = seg_plus1;
                        consec_next = 4'd0;
                    end
                    if (bus.i_speed_valid) begin
                        speed_next = over ? SC_SLOW : (under ? SC_UP : SC_HOLD);
                        if (out_band) begin
                            consec_next = consec_inc;
                            viol_next   = (viol_reg == 8'hFF) ? 8'hFF : viol_reg + 8'd1;
                        end else begin
                            consec_next = 4'd0;
                        end
                    end
                    if (alarm_hit) speed_next = SC_SLOW;
                end
            end
            S_ALARM:   speed_next = human ? SC_HOLD : SC_SLOW;
            S_ARRIVED: begin
                if (bus.i_speed_valid) speed_next = (bus.i_speed != '0) ? SC_SLOW : SC_HOLD;
                if (bus.i_start)       speed_next = SC_HOLD;
            end
            default:   speed_next = SC_HOLD;
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            seg_reg    <= 3'd0;
            speed_reg  <= SC_HOLD;
            viol_reg   <= 8'd0;
            consec_reg <= 4'd0;
            weight_reg <= '0;
        end else begin
            seg_reg    <= seg_next;
            speed_reg  <= speed_next;
            viol_reg   <= viol_next;
            consec_reg <= consec_next;
            weight_reg <= weight_next;
        end
    end
endmodule

// File: tb/tb_coaster_segment_monitor.sv
// Self-checking bench for coaster_segment_monitor: directed ride scenarios
// followed by random traffic, all compared against a rule-level model.
module tb_coaster_segment_monitor;
    localparam int NUM_SEG = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    coaster_segment_monitor_if #(.NUM_SEG(NUM_SEG), .SPEED_W(9), .WEIGHT_W(12)) bus ();

    coaster_segment_monitor dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int step_no = 0;

    // Reference model: ride state described with plain integers
    int lo [NUM_SEG] = '{25, 20, 10, 10};
    int hi [NUM_SEG] = '{30, 50, 20, 30};
    int m_state = 0;   // 0 idle, 1 run, 2 alarm, 3 arrived, 4 reject
    int m_seg = 0;
    int m_sc = 0;
    int m_viol = 0;
    int m_consec = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_tick(input bit r, input bit start, input int weight, input int speed,
                              input bit valid, input bit [3:0] ir, input bit human);
        if (r) begin
            m_state = 0; m_seg = 0; m_sc = 0; m_viol = 0; m_consec = 0;
            return;
        end
        case (m_state)
            0: begin
                m_sc = 0;
                if (start) begin
                    if (weight > 300 && weight < 1500) begin
                        m_state = 1; m_seg = 0; m_viol = 0; m_consec = 0;
                    end else begin
                        m_state = 4;
                    end
                end
            end
            4: begin m_state = 0; m_sc = 0; end
            1: begin
                if (human) begin
                    m_state = 2; m_sc = 2;
                end else begin
                    if (m_seg < NUM_SEG - 1 && ir[m_seg + 1]) begin
                        m_seg++; m_consec = 0;
                    end
                    if (valid) begin
                        if (speed > hi[m_seg])      m_sc = 2;
                        else if (speed < lo[m_seg]) m_sc = 1;
                        else                        m_sc = 0;
                        if (m_sc != 0) begin
                            m_consec = (m_consec < 15) ? m_consec + 1 : 15;
                            m_viol   = (m_viol < 255) ? m_viol + 1 : 255;
                        end else begin
                            m_consec = 0;
                        end
                    end
                    if (m_seg == NUM_SEG - 1) m_state = 3;
                    else if (m_consec >= 3) begin m_state = 2; m_sc = 2; end
                end
            end
            2: begin
                m_sc = 2;
                if (human) begin m_state = 0; m_sc = 0; end
            end
            3: begin
                if (valid) m_sc = (speed != 0) ? 2 : 0;
                if (start) begin m_state = 0; m_sc = 0; end
            end
            default: m_state = 0;
        endcase
    endtask

    // One clock of stimulus, then compare every output against the model
    task automatic step(input bit r, input bit start, input int weight, input int speed,
                        input bit valid, input bit [3:0] ir, input bit human);
        rst                 = r;
        bus.i_start         = start;
        bus.i_weight        = 12'(weight);
        bus.i_speed         = 9'(speed);
        bus.i_speed_valid   = valid;
        bus.i_ir_sensor     = ir;
        bus.i_human_control = human;
        model_tick(r, start, weight, speed, valid, ir, human);
        @(posedge clk);
        #1;
        step_no++;
        check("state",   32'(bus.o_state),         32'(m_state));
        check("segment", 32'(bus.o_segment),       32'(m_seg));
        check("speed",   32'(bus.o_speed_control), 32'(m_sc));
        check("alarm",   32'(bus.o_alarm),         32'(m_state == 2));
        check("dest",    32'(bus.o_destination),   32'(m_state == 3));
        check("viol",    32'(bus.o_viol_cnt),      32'(m_viol));
        $display("[TB] step %0d rst=%0b st=%0b w=%0d v=%0d/%0b ir=%b hc=%0b -> state=%0d seg=%0d sc=%0d viol=%0d",
                 step_no, r, start, weight, speed, valid, ir, human,
                 bus.o_state, bus.o_segment, bus.o_speed_control, bus.o_viol_cnt);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 4'b0000, 0);
    endtask

    task automatic sample(input int speed);
        step(0, 0, 0, speed, 1, 4'b0000, 0);
    endtask

    task automatic start_ride(input int weight);
        step(0, 1, weight, 0, 0, 4'b0000, 0);
    endtask

    initial begin
        bus.i_start = 0; bus.i_weight = 0; bus.i_speed = 0; bus.i_speed_valid = 0;
        bus.i_ir_sensor = 0; bus.i_human_control = 0;
        @(negedge clk);

        // Reset values
        step(1, 0, 0, 0, 0, 4'b0000, 0);
        step(1, 0, 0, 0, 0, 4'b0000, 0);
        check("rst_state", 32'(bus.o_state), 32'd0);
        check("rst_speed", 32'(bus.o_speed_control), 32'd0);

        // Weight 1234, samples 27/35/20 in segment 0
        start_ride(1234);
        check("start_run", 32'(bus.o_state), 32'd1);
        sample(27); check("s0_27", 32'(bus.o_speed_control), 32'd0);
        sample(35); check("s0_35", 32'(bus.o_speed_control), 32'd2);
        sample(20); check("s0_20", 32'(bus.o_speed_control), 32'd1);
        check("s0_viol", 32'(bus.o_viol_cnt), 32'd2);
        check("s0_noalarm", 32'(bus.o_alarm), 32'd0);
        step(0, 0, 0, 0, 0, 4'b0000, 1);   // abort from RUN
        check("abort_alarm", 32'(bus.o_state), 32'd2);
        step(0, 0, 0, 0, 0, 4'b0000, 1);
        check("ack_idle", 32'(bus.o_state), 32'd0);

        // Boundary weights are rejected for exactly one cycle
        start_ride(300);
        check("w300_rej", 32'(bus.o_state), 32'd4);
        idle_step();
        check("w300_idle", 32'(bus.o_state), 32'd0);
        start_ride(1500);
        check("w1500_rej", 32'(bus.o_state), 32'd4);
        check("w1500_seg", 32'(bus.o_segment), 32'd0);
        idle_step();
        check("w1500_idle", 32'(bus.o_state), 32'd0);

        // Three overspeed samples in segment 1 raise the alarm
        start_ride(800);
        step(0, 0, 0, 0, 0, 4'b0010, 0);
        sample(60); sample(60);
        check("hold_run", 32'(bus.o_state), 32'd1);
        sample(60);
        check("hold_alarm", 32'(bus.o_alarm), 32'd1);
        check("hold_slow", 32'(bus.o_speed_control), 32'd2);
        sample(30);
        check("alarm_stays_slow", 32'(bus.o_speed_control), 32'd2);
        step(0, 0, 0, 0, 0, 4'b0000, 1);
        check("alarm_ack", 32'(bus.o_state), 32'd0);

        // Sensors 1,3,2,3: out-of-order sensor ignored, then arrival and braking
        start_ride(1000);
        step(0, 0, 0, 0, 0, 4'b0010, 0); check("seq_s1", 32'(bus.o_segment), 32'd1);
        step(0, 0, 0, 0, 0, 4'b1000, 0); check("seq_s3", 32'(bus.o_segment), 32'd1);
        step(0, 0, 0, 0, 0, 4'b0100, 0); check("seq_s2", 32'(bus.o_segment), 32'd2);
        step(0, 0, 0, 0, 0, 4'b1000, 0);
        check("arrived", 32'(bus.o_destination), 32'd1);
        sample(15); check("arr_15", 32'(bus.o_speed_control), 32'd2);
        sample(0);  check("arr_0", 32'(bus.o_speed_control), 32'd0);
        step(0, 0, 0, 0, 0, 4'b0000, 1);   // operator input has no effect in ARRIVED
        check("arr_hold", 32'(bus.o_state), 32'd3);
        start_ride(100);                   // weight not evaluated when leaving ARRIVED
        check("arr_idle", 32'(bus.o_state), 32'd0);

        // Advance coinciding with a sample uses the new segment's band
        start_ride(700);
        step(0, 0, 0, 45, 1, 4'b0010, 0);
        check("adv_seg", 32'(bus.o_segment), 32'd1);
        check("adv_speed", 32'(bus.o_speed_control), 32'd0);

        // Reach segment 2 with five violations, then reset mid-ride with a sample
        step(0, 0, 0, 0, 0, 4'b0100, 0);
        sample(25); sample(25); sample(15); sample(25); sample(25); sample(15); sample(25);
        check("pre_rst_viol", 32'(bus.o_viol_cnt), 32'd5);
        check("pre_rst_seg", 32'(bus.o_segment), 32'd2);
        step(1, 0, 0, 99, 1, 4'b1000, 0);
        check("rst_viol", 32'(bus.o_viol_cnt), 32'd0);
        check("rst_seg", 32'(bus.o_segment), 32'd0);
        check("rst_st", 32'(bus.o_state), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit r, st, vl, hc;
            int w, sp;
            bit [3:0] ir;
            r  = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 12);
            hc = ($urandom_range(0, 99) < 4);
            vl = ($urandom_range(0, 99) < 60);
            w  = $urandom_range(250, 1600);
            sp = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 63);
            ir = ($urandom_range(0, 99) < 20) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step(r, st, w, sp, vl, ir, hc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
